// File: rtl/wbh_pkg.sv
// wbh_pkg: shared definitions for the wishbone external bridge.
//   - FSM state encoding
//   - response data returned when a downstream access times out
//   - bit positions of the local bank/status register
package wbh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } wbh_state_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_0BAD;

    // Local register layout: [7:0] bank, [8] sticky timeout flag, rest zero.
    localparam int BANK_LSB    = 0;
    localparam int BANK_MSB    = 7;
    localparam int TO_FLAG_BIT = 8;

    function automatic logic [31:0] local_reg_value(input logic [7:0] bank,
                                                    input logic       to_flag);
        return {23'd0, to_flag, bank};
    endfunction

endpackage

// File: rtl/wbh_timeout_cnt.sv
// wbh_timeout_cnt: loadable down-counter with clear, enable and a
// terminal-count flag.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : force the count to zero
//   load      : load load_val (priority over clr and en)
//   load_val  : value to load
//   en        : decrement by one, saturating at zero
//   tc        : count is zero
module wbh_timeout_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/wbh_ext_bridge.sv
// wbh_ext_bridge: single-outstanding wishbone bridge from the management
// SoC port (wbd_ext_*) to the internal wishbone master port (wbm_*).
// The top address byte of forwarded accesses comes from a local bank
// register at LOCAL_ADDR; a timeout aborts downstream accesses that never
// complete, returning TIMEOUT_DATA with err and setting a sticky flag.
//   wb_clk_i / wb_rst_i      : clock, asynchronous active-high reset
//   wbd_ext_* (inputs)       : upstream request (cyc, stb, we, sel, adr, dat)
//   wbd_ext_ack_o/err_o/dat_o: one-cycle registered response
//   wbm_* (outputs)          : registered downstream request
//   wbm_ack_i/err_i/dat_i    : downstream response
// Handshake: upstream request is taken when cyc & stb are high in IDLE;
// completion is a single-cycle ack (err alongside); downstream cyc/stb stay
// high with stable attributes until ack or err is seen.
module wbh_ext_bridge
    import wbh_pkg::*;
#(
    parameter logic [31:0] LOCAL_ADDR = 32'h3080_0000,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [7:0]  BANK_RST   = 8'h10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbd_ext_cyc_i,
    input  logic        wbd_ext_stb_i,
    input  logic        wbd_ext_we_i,
    input  logic [3:0]  wbd_ext_sel_i,
    input  logic [31:0] wbd_ext_adr_i,
    input  logic [31:0] wbd_ext_dat_i,
    output logic        wbd_ext_ack_o,
    output logic        wbd_ext_err_o,
    output logic [31:0] wbd_ext_dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Loaded on entry to REQ; reaching zero marks the TIMEOUT-th REQ edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    wbh_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] adr_q, adr_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rdat_q, rdat_d;
    logic        err_q, err_d;
    logic [7:0]  bank_q, bank_d;
    logic        to_flag_q, to_flag_d;
    logic        ack_o_q, ack_o_d;
    logic        err_o_q, err_o_d;
    logic [31:0] dat_o_q, dat_o_d;

    logic cnt_load, cnt_clr, cnt_en, cnt_tc;
    logic accept, is_local;

    // While ack is out the master has not yet dropped stb; ignoring the
    // request for that cycle avoids re-accepting the finished transfer.
    assign accept   = wbd_ext_cyc_i & wbd_ext_stb_i & ~ack_o_q;
    assign is_local = (wbd_ext_adr_i == LOCAL_ADDR);

    wbh_timeout_cnt #(.W(CNT_W)) u_timeout_cnt (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        adr_d     = adr_q;
        cyc_d     = cyc_q;
        rdat_d    = rdat_q;
        err_d     = err_q;
        bank_d    = bank_q;
        to_flag_d = to_flag_q;
        ack_o_d   = 1'b0;
        err_o_d   = 1'b0;
        dat_o_d   = '0;
        cnt_load  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (accept) begin
                    we_d   = wbd_ext_we_i;
                    sel_d  = wbd_ext_sel_i;
                    wdat_d = wbd_ext_dat_i;
                    if (is_local) begin
                        // Read data is the register value before this write.
                        rdat_d = local_reg_value(bank_q, to_flag_q);
                        err_d  = 1'b0;
                        if (wbd_ext_we_i && wbd_ext_sel_i[0]) begin
                            bank_d = wbd_ext_dat_i[BANK_MSB:BANK_LSB];
                        end
                        if (wbd_ext_we_i && wbd_ext_sel_i[1] && wbd_ext_dat_i[TO_FLAG_BIT]) begin
                            to_flag_d = 1'b0;
                        end
                        state_d = ST_RESP;
                    end else begin
                        adr_d    = {bank_q, wbd_ext_adr_i[23:0]};
                        cyc_d    = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_en = 1'b1;
                // A slave response takes precedence over an expiring timer.
                if (wbm_ack_i || wbm_err_i) begin
                    rdat_d  = we_q ? 32'd0 : wbm_dat_i;
                    err_d   = wbm_err_i;
                    cyc_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_tc) begin
                    rdat_d    = TIMEOUT_DATA;
                    err_d     = 1'b1;
                    to_flag_d = 1'b1;
                    cyc_d     = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                ack_o_d = 1'b1;
                err_o_d = err_q;
                dat_o_d = rdat_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            sel_q     <= '0;
            wdat_q    <= '0;
            adr_q     <= '0;
            cyc_q     <= 1'b0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            bank_q    <= BANK_RST;
            to_flag_q <= 1'b0;
            ack_o_q   <= 1'b0;
            err_o_q   <= 1'b0;
            dat_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            adr_q     <= adr_d;
            cyc_q     <= cyc_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
            bank_q    <= bank_d;
            to_flag_q <= to_flag_d;
            ack_o_q   <= ack_o_d;
            err_o_q   <= err_o_d;
            dat_o_q   <= dat_o_d;
        end
    end

    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = wdat_q;
    assign wbd_ext_ack_o = ack_o_q;
    assign wbd_ext_err_o = err_o_q;
    assign wbd_ext_dat_o = dat_o_q;

endmodule

// File: tb/tb_wbh_ext_bridge.sv
// tb_wbh_ext_bridge: directed and randomized checks of wbh_ext_bridge
// against a transaction-level model (bank, sticky flag, latency rules).
module tb_wbh_ext_bridge;

    localparam logic [31:0] LOCAL_A   = 32'h3080_0000;
    localparam int          T         = 8;
    localparam int          ACK_LIMIT = 60;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        cyc_i, stb_i, we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i, dat_i;
    logic        wbd_ext_ack_o, wbd_ext_err_o;
    logic [31:0] wbd_ext_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] wbm_dat_i;

    wbh_ext_bridge #(
        .LOCAL_ADDR (LOCAL_A),
        .TIMEOUT    (T),
        .BANK_RST   (8'h10)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbd_ext_cyc_i (cyc_i),
        .wbd_ext_stb_i (stb_i),
        .wbd_ext_we_i  (we_i),
        .wbd_ext_sel_i (sel_i),
        .wbd_ext_adr_i (adr_i),
        .wbd_ext_dat_i (dat_i),
        .wbd_ext_ack_o (wbd_ext_ack_o),
        .wbd_ext_err_o (wbd_ext_err_o),
        .wbd_ext_dat_o (wbd_ext_dat_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_ack_i     (wbm_ack_i),
        .wbm_err_i     (wbm_err_i),
        .wbm_dat_i     (wbm_dat_i)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  m_bank;
    logic        m_to_flag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- downstream slave model ----------------
    // mode 0: ack after slv_waits wait states, 1: err after slv_waits, 2: never respond
    int          slv_mode  = 0;
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    int          stb_cnt = 0;
    int          stb_cycles = 0;
    int          stb_total = 0;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;
    logic        obs_unstable = 1'b0;

    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
    end

    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) begin
            if (stb_cnt == 0) begin
                obs_adr      = wbm_adr_o;
                obs_dat      = wbm_dat_o;
                obs_sel      = wbm_sel_o;
                obs_we       = wbm_we_o;
                obs_unstable = 1'b0;
                stb_cycles   = 0;
            end else if (wbm_adr_o !== obs_adr || wbm_dat_o !== obs_dat ||
                         wbm_sel_o !== obs_sel || wbm_we_o !== obs_we) begin
                obs_unstable = 1'b1;
            end
            stb_cycles++;
            stb_total++;
            if (slv_mode != 2 && stb_cnt == slv_waits) begin
                wbm_ack_i = (slv_mode == 0);
                wbm_err_i = (slv_mode == 1);
                wbm_dat_i = slv_rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            stb_cnt++;
        end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            stb_cnt   = 0;
        end
    end

    // ---------------- upstream driver ----------------
    // Called just after a rising edge; the request is sampled on the next edge.
    // lat = edges until ack is seen (0 if it never came within ACK_LIMIT).
    task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, output logic [31:0] rdat,
                        output logic err, output int lat);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
        lat = 0; rdat = '0; err = 1'b0;
        for (int i = 1; i <= ACK_LIMIT; i++) begin
            @(posedge clk); #1;
            if (wbd_ext_ack_o) begin
                lat  = i;
                rdat = wbd_ext_dat_o;
                err  = wbd_ext_err_o;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_single_cycle", 32'(wbd_ext_ack_o), 32'd0);
    endtask

    task automatic run_local(input string tag, input logic we, input logic [3:0] sel,
                             input logic [31:0] dat);
        logic [31:0] rdat;
        logic        err;
        int          lat;
        int          stb_before;
        if (!we) exp_q.push_back({23'd0, m_to_flag, m_bank});
        stb_before = stb_total;
        xfer(we, sel, LOCAL_A, dat, rdat, err, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_no_fwd"}, 32'(stb_total - stb_before), 32'd0);
        if (!we) chk({tag, "_rdata"}, rdat, exp_q.pop_front());
        if (we && sel[0]) m_bank = dat[7:0];
        if (we && sel[1] && dat[8]) m_to_flag = 1'b0;
    endtask

    task automatic run_fwd(input string tag, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input int mode, input int waits, input logic [31:0] rdata);
        logic [31:0] rdat;
        logic        err;
        int          lat;
        int          exp_lat, exp_stb;
        logic        exp_err;
        logic [31:0] exp_adr;
        exp_adr = {m_bank, adr[23:0]};
        if (mode == 2) begin
            exp_lat = T + 2; exp_stb = T; exp_err = 1'b1;
            exp_q.push_back(32'hDEAD_0BAD);
        end else begin
            exp_lat = waits + 3; exp_stb = waits + 1; exp_err = (mode == 1);
            if (mode == 0 && !we) exp_q.push_back(rdata);
        end
        slv_mode = mode; slv_waits = waits; slv_rdata = rdata;
        xfer(we, sel, adr, dat, rdat, err, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_stb_cycles"}, 32'(stb_cycles), 32'(exp_stb));
        chk({tag, "_wbm_adr"}, obs_adr, exp_adr);
        chk({tag, "_wbm_we"}, 32'(obs_we), 32'(we));
        chk({tag, "_wbm_sel"}, 32'(obs_sel), 32'(sel));
        chk({tag, "_wbm_stable"}, 32'(obs_unstable), 32'd0);
        if (we) chk({tag, "_wbm_dat"}, obs_dat, dat);
        if (exp_q.size() > 0) chk({tag, "_rdata"}, rdat, exp_q.pop_front());
        if (mode == 2) m_to_flag = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
                                wbd_ext_ack_o, wbd_ext_err_o}), 32'd0);
        chk({tag, "_wbm_adr"}, wbm_adr_o, 32'd0);
        chk({tag, "_wbm_dat"}, wbm_dat_o, 32'd0);
        chk({tag, "_dat_o"}, wbd_ext_dat_o, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int          ack_seen;
        logic [31:0] radr;
        rst = 1'b1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0; adr_i = '0; dat_i = '0;
        m_bank = 8'h10; m_to_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_local("rd_reset_bank", 1'b0, 4'hF, 32'd0);
        run_local("wr_bank_a5", 1'b1, 4'b0001, 32'h0000_00A5);
        run_fwd("fwd_wr_0wait", 1'b1, 4'hF, 32'h3000_0040, 32'h1234_5678, 0, 0, 32'd0);
        run_fwd("fwd_rd_5wait", 1'b0, 4'hF, 32'h3000_0100, 32'd0, 0, 5, 32'hCAFE_F00D);
        run_fwd("fwd_timeout", 1'b0, 4'hF, 32'h3000_0200, 32'd0, 2, 0, 32'd0);
        run_local("rd_to_flag_set", 1'b0, 4'hF, 32'd0);
        run_local("wr_clr_keep_sel", 1'b1, 4'b0001, 32'h0000_01A5); // sel[1]=0: flag stays
        run_local("rd_flag_kept", 1'b0, 4'hF, 32'd0);
        run_local("wr_clr_flag", 1'b1, 4'b0010, 32'h0000_0100);
        run_local("rd_flag_clear", 1'b0, 4'hF, 32'd0);
        run_fwd("fwd_slave_err", 1'b0, 4'hF, 32'h3000_0300, 32'd0, 1, 2, 32'h5555_AAAA);
        run_local("rd_after_err", 1'b0, 4'hF, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_local("rnd_local", 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end else begin
                int mode_sel;
                int mode;
                radr = $urandom;
                if (radr == LOCAL_A) radr = radr ^ 32'h4;
                mode_sel = $urandom_range(0, 5);
                mode = (mode_sel < 4) ? 0 : (mode_sel == 4 ? 1 : 2);
                run_fwd("rnd_fwd", 1'($urandom_range(0, 1)), 4'($urandom), radr, $urandom,
                        mode, $urandom_range(0, 6), $urandom);
            end
        end

        // Reset in the middle of a downstream access
        run_fwd("pre_rst_timeout", 1'b0, 4'hF, 32'h3000_0400, 32'd0, 2, 0, 32'd0);
        run_local("pre_rst_bank", 1'b1, 4'b0001, 32'h0000_005C);
        slv_mode = 2;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hF;
        adr_i = 32'h3000_0500; dat_i = 32'h0BAD_F00D;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_req_stb_before_rst", 32'(wbm_stb_o), 32'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid_req_rst");
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_bank = 8'h10; m_to_flag = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < T + 4; i++) begin
            @(posedge clk); #1;
            if (wbd_ext_ack_o) ack_seen++;
        end
        chk("no_ack_after_rst", 32'(ack_seen), 32'd0);
        run_local("rd_after_rst", 1'b0, 4'hF, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
